fft_stage_tw_addr_gen: RTL

Twiddle read-side sequencer for one radix-2 single-path delay-feedback (SDF) decimation-in-frequency stage of the pipeline FFT. It counts the incoming sample stream and derives, per sample, the butterfly phase and the twiddle ROM index. It drives the enable and angle pointer of that stage's twiddle ROM. It re-times the sample data and sideband flags by the ROM's one-cycle read latency, so that they arrive aligned with the ROM's `cos_data`/`sin_data` at the complex multiplier.

---
 rtl/fft_stage_tw_addr_gen.sv | 60 ++++++
 1 files changed

// File: rtl/fft_stage_tw_addr_gen.sv
// fft_stage_tw_addr_gen: SDF stage twiddle ROM sequencer with one-cycle data retiming
module fft_stage_tw_addr_gen #(
  parameter int N = 256,
  parameter int SIZE = 8,
  parameter int STAGE = 6,
  parameter int bit_width = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic signed [bit_width-1:0] in_re,
  input  logic signed [bit_width-1:0] in_im,
  output logic                        bf_sel,
  output logic                        tw_en,
  output logic [SIZE-STAGE-1:0]       tw_rd_ptr,
  output logic                        out_valid,
  output logic                        out_sof,
  output logic signed [bit_width-1:0] out_re,
  output logic signed [bit_width-1:0] out_im,
  output logic                        out_bf_sel,
  output logic                        out_tw_apply
);
  localparam int W = SIZE - STAGE;
  logic sof;
  logic [SIZE-1:0] cnt_q, cnt_d, pos;
  logic primed_q, primed_d;
  always_comb begin
    sof = in_valid & in_sof;
    pos = sof ? '0 : cnt_q;
    bf_sel = pos[W];
    tw_rd_ptr = bf_sel ? '0 : pos[W-1:0];
    tw_en = in_valid;
    cnt_d = (pos == SIZE'(N - 1)) ? '0 : pos + SIZE'(1);
    primed_d = ~sof & (primed_q | bf_sel);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      primed_q <= 1'b0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      out_tw_apply <= 1'b0;
      out_re <= '0;
      out_im <= '0;
      out_bf_sel <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_sof <= sof;
      out_tw_apply <= in_valid & ~bf_sel & primed_q & ~sof;
      if (in_valid) begin
        cnt_q <= cnt_d;
        primed_q <= primed_d;
        out_re <= in_re;
        out_im <= in_im;
        out_bf_sel <= bf_sel;
      end
    end
  end
endmodule
